mem_bus_arbiter: RTL and testbench
==================================

// Module: mem_bus_arbiter
// PURPOSE
//  Shares one SRAM-style memory bus between the core's instruction-fetch port (IF) and data-memory port (DM).
//  Sits between the core and the bus bridge toward the AXI-Lite interconnect.
//  Grants one transaction at a time, latches its command and returns read data to the winner.
//  Aborts stuck transactions through a watchdog and reports them as errors.
// PARAMETERS
//  ADDR_W     32   address width, both ports and bus
//  DATA_W     32   data width; wstrb width is DATA_W/8
//  PRIO_DATA  1    1: DM wins every tie; 0: round-robin on ties
//  TIMEOUT    255  max BUSY cycles before abort; 0 disables the watchdog
// PORTS
//  clk        in   1          clock, rising edge
//  rst        in   1          async reset, active-high
//  if_req     in   1          IF read request, held until if_ack
//  if_addr    in   ADDR_W     IF read address
//  if_ack     out  1          IF done, 1-cycle pulse
//  dm_req     in   1          DM request, held until dm_ack
//  dm_we      in   1          DM write enable
//  dm_addr    in   ADDR_W     DM address
//  dm_wdata   in   DATA_W     DM write data
//  dm_wstrb   in   DATA_W/8   DM byte strobes
//  dm_ack     out  1          DM done, 1-cycle pulse
//  rsp_rdata  out  DATA_W     read data; valid while if_ack or dm_ack is high
//  rsp_err    out  1          timeout flag; valid while if_ack or dm_ack is high
//  m_req      out  1          bus request, held until m_ack or abort
//  m_we       out  1          bus write enable
//  m_addr     out  ADDR_W     bus address
//  m_wdata    out  DATA_W     bus write data
//  m_wstrb    out  DATA_W/8   bus byte strobes
//  m_ack      in   1          bus completion, 1-cycle pulse; may come in the first m_req cycle
//  m_rdata    in   DATA_W     bus read data, valid with m_ack
// BEHAVIOUR
//  - Reset: all outputs registered and 0; state=IDLE; watchdog=0; last_grant=DM, so the first RR tie goes to IF.
//  - FSM: IDLE -> BUSY -> RESP -> IDLE.
//  - IDLE: sample if_req/dm_req.
//    - One request: grant it.
//    - Both requests: PRIO_DATA=1 grants DM; PRIO_DATA=0 grants the port that is not last_grant.
//    - On grant, next edge: latch the command into m_*, set m_req=1, go to BUSY, update last_grant.
//    - IF grants drive m_we=0, m_wstrb=0, m_wdata=0.
//  - BUSY: m_* held stable.
//    - Watchdog increments each BUSY cycle without m_ack.
//    - On m_ack, next edge: m_req=0, rsp_rdata=m_rdata, rsp_err=0, winner's ack=1, go to RESP.
//  - Timeout: watchdog reaches TIMEOUT with no m_ack (TIMEOUT!=0), next edge:
//    - m_req=0, rsp_rdata=0, rsp_err=1, winner's ack=1, go to RESP.
//    - An m_ack arriving in that same cycle takes precedence: normal completion.
//  - RESP: ack high for exactly one cycle, then IDLE; watchdog cleared.
//    - Requester drops req in the RESP cycle, so IDLE never re-grants a finished request.
//  - Latency: request seen in IDLE at cycle 0 -> m_req at cycle 1 -> ack one cycle after m_ack. Min 3 cycles per transaction.
//  - Requests arriving or dropped during BUSY/RESP are ignored. A granted transaction always completes and pulses ack.
//  - m_ack in IDLE/RESP is ignored.
//  - rst mid-transaction: m_req and all acks drop immediately; the transaction is lost and the requester reissues.
//  - Watchdog width: $clog2(TIMEOUT+1); saturates and never wraps.
// STRUCTURE
//  - Shared package/define header: state encodings (IDLE/BUSY/RESP), port ids (PORT_IF/PORT_DM), bus width macros.
//  - One sub-module: mem_arb_pick2, the combinational tie-break (req_if, req_dm, last_grant, PRIO_DATA -> grant).
//  - FSM, command latch and watchdog stay in the top.
// TESTING
//  1. IF only: if_addr=0x100, slave acks cycle 2 with 0xDEADBEEF -> m_req cycles 1-2, if_ack cycle 3, rsp_rdata=0xDEADBEEF, rsp_err=0.
//  2. DM write: addr=0x2000_0004, wdata=0x1234_5678, wstrb=4'b0011 -> m_we=1, same m_* held until m_ack; dm_ack pulses once.
//  3. Tie, PRIO_DATA=0: both held for 4 transactions -> grants IF,DM,IF,DM. With PRIO_DATA=1 -> DM wins every tie.
//  4. TIMEOUT=8, slave never acks -> m_req drops after 8 BUSY cycles; ack pulses with rsp_err=1, rsp_rdata=0; next request served normally.
//  5. rst pulsed mid-BUSY -> outputs 0 asynchronously; after release, a fresh IF request completes normally.
//  6. m_ack in the first m_req cycle -> ack one cycle later; spurious m_ack in IDLE -> no ack, no state change.

Source files
------------

// File: rtl/mem_bus_arbiter_pkg.sv
// Package: mem_bus_arbiter_pkg
// Purpose: shared types and default widths for the IF/DM memory bus arbiter.
//   arb_state_t : IDLE -> BUSY -> RESP transaction sequencing
//   port_t      : identifies which core port owns the bus
//   DEF_*       : default bus widths used by the arbiter and its users
package mem_bus_arbiter_pkg;

  localparam int DEF_ADDR_W = 32;
  localparam int DEF_DATA_W = 32;
  localparam int DEF_STRB_W = DEF_DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_BUSY = 2'd1,
    ST_RESP = 2'd2
  } arb_state_t;

  typedef enum logic {
    PORT_IF = 1'b0,
    PORT_DM = 1'b1
  } port_t;

endpackage

// File: rtl/mem_bus_arbiter_pick2.sv
// Module: mem_arb_pick2
// Purpose: combinational two-way tie-break between the IF and DM ports.
// Ports:
//   req_if, req_dm : live request lines from the two ports
//   last_grant     : port that won the previous grant
//   grant_valid    : at least one port is requesting
//   grant          : winning port (meaningful only when grant_valid is high)
// PRIO_DATA != 0 makes DM win every tie; otherwise ties alternate away from last_grant.
module mem_arb_pick2
  import mem_bus_arbiter_pkg::*;
#(
  parameter int PRIO_DATA = 1
) (
  input  logic  req_if,
  input  logic  req_dm,
  input  port_t last_grant,
  output logic  grant_valid,
  output port_t grant
);

  always_comb begin
    grant_valid = req_if | req_dm;
    grant       = PORT_IF;
    if (req_if && req_dm) begin
      if (PRIO_DATA != 0) begin
        grant = PORT_DM;
      end else if (last_grant == PORT_DM) begin
        grant = PORT_IF;
      end else begin
        grant = PORT_DM;
      end
    end else if (req_dm) begin
      grant = PORT_DM;
    end
  end

endmodule

// File: rtl/mem_bus_arbiter.sv
// Module: mem_bus_arbiter
// Purpose: shares one SRAM-style bus between the instruction-fetch (IF) and
//   data-memory (DM) ports. One transaction at a time: the winner's command is
//   latched onto m_*, read data is returned with a one-cycle ack, and a
//   watchdog aborts transactions the bus never acknowledges (rsp_err=1).
// Ports:
//   clk, rst                      : clock (rising edge), async active-high reset
//   if_req/if_addr/if_ack         : IF read port, req held until ack pulse
//   dm_req/dm_we/dm_addr/dm_wdata/dm_wstrb/dm_ack : DM read/write port
//   rsp_rdata, rsp_err            : response, valid while if_ack or dm_ack
//   m_req/m_we/m_addr/m_wdata/m_wstrb : bus command, held until m_ack or abort
//   m_ack, m_rdata                : bus completion pulse and read data
module mem_bus_arbiter
  import mem_bus_arbiter_pkg::*;
#(
  parameter int ADDR_W    = DEF_ADDR_W,
  parameter int DATA_W    = DEF_DATA_W,
  parameter int PRIO_DATA = 1,
  parameter int TIMEOUT   = 255
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                if_req,
  input  logic [ADDR_W-1:0]   if_addr,
  output logic                if_ack,
  input  logic                dm_req,
  input  logic                dm_we,
  input  logic [ADDR_W-1:0]   dm_addr,
  input  logic [DATA_W-1:0]   dm_wdata,
  input  logic [DATA_W/8-1:0] dm_wstrb,
  output logic                dm_ack,
  output logic [DATA_W-1:0]   rsp_rdata,
  output logic                rsp_err,
  output logic                m_req,
  output logic                m_we,
  output logic [ADDR_W-1:0]   m_addr,
  output logic [DATA_W-1:0]   m_wdata,
  output logic [DATA_W/8-1:0] m_wstrb,
  input  logic                m_ack,
  input  logic [DATA_W-1:0]   m_rdata
);

  localparam int STRB_W = DATA_W / 8;
  // A disabled watchdog (TIMEOUT=0) still needs a legal one-bit counter.
  localparam int WD_W = (TIMEOUT > 0) ? $clog2(TIMEOUT + 1) : 1;
  localparam logic [WD_W-1:0] WD_LIMIT = WD_W'(TIMEOUT);
  localparam logic [WD_W-1:0] WD_MAX   = '1;

  arb_state_t        state_q, state_d;
  port_t             cur_port, cur_port_d;
  port_t             last_grant, last_grant_d;
  logic [WD_W-1:0]   wdog, wdog_d, wdog_inc;
  logic              timeout_hit;

  logic              grant_valid;
  port_t             grant;

  logic              if_ack_d, dm_ack_d, rsp_err_d, m_req_d, m_we_d;
  logic [DATA_W-1:0] rsp_rdata_d, m_wdata_d;
  logic [ADDR_W-1:0] m_addr_d;
  logic [STRB_W-1:0] m_wstrb_d;

  mem_arb_pick2 #(
    .PRIO_DATA(PRIO_DATA)
  ) u_pick (
    .req_if     (if_req),
    .req_dm     (dm_req),
    .last_grant (last_grant),
    .grant_valid(grant_valid),
    .grant      (grant)
  );

  // Saturating increment; the abort fires on the BUSY cycle whose increment
  // would reach TIMEOUT, so m_req stays high for exactly TIMEOUT cycles.
  assign wdog_inc    = (wdog == WD_MAX) ? wdog : wdog + WD_W'(1);
  assign timeout_hit = (TIMEOUT != 0) && (wdog_inc == WD_LIMIT);

  always_comb begin
    state_d      = state_q;
    cur_port_d   = cur_port;
    last_grant_d = last_grant;
    wdog_d       = wdog;
    if_ack_d     = 1'b0;
    dm_ack_d     = 1'b0;
    rsp_rdata_d  = rsp_rdata;
    rsp_err_d    = rsp_err;
    m_req_d      = m_req;
    m_we_d       = m_we;
    m_addr_d     = m_addr;
    m_wdata_d    = m_wdata;
    m_wstrb_d    = m_wstrb;

    unique case (state_q)
      ST_IDLE: begin
        wdog_d = '0;
        if (grant_valid) begin
          cur_port_d   = grant;
          last_grant_d = grant;
          m_req_d      = 1'b1;
          state_d      = ST_BUSY;
          if (grant == PORT_DM) begin
            m_we_d    = dm_we;
            m_addr_d  = dm_addr;
            m_wdata_d = dm_wdata;
            m_wstrb_d = dm_wstrb;
          end else begin
            m_we_d    = 1'b0;
            m_addr_d  = if_addr;
            m_wdata_d = '0;
            m_wstrb_d = '0;
          end
        end
      end

      // A late m_ack in the timeout cycle still counts as a normal completion.
      ST_BUSY: begin
        if (m_ack) begin
          m_req_d     = 1'b0;
          rsp_rdata_d = m_rdata;
          rsp_err_d   = 1'b0;
          if_ack_d    = (cur_port == PORT_IF);
          dm_ack_d    = (cur_port == PORT_DM);
          state_d     = ST_RESP;
        end else if (timeout_hit) begin
          m_req_d     = 1'b0;
          rsp_rdata_d = '0;
          rsp_err_d   = 1'b1;
          if_ack_d    = (cur_port == PORT_IF);
          dm_ack_d    = (cur_port == PORT_DM);
          state_d     = ST_RESP;
        end else begin
          wdog_d = wdog_inc;
        end
      end

      ST_RESP: begin
        wdog_d  = '0;
        state_d = ST_IDLE;
      end

      default: begin
        wdog_d  = '0;
        m_req_d = 1'b0;
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      cur_port   <= PORT_IF;
      last_grant <= PORT_DM;
      wdog       <= '0;
      if_ack     <= 1'b0;
      dm_ack     <= 1'b0;
      rsp_rdata  <= '0;
      rsp_err    <= 1'b0;
      m_req      <= 1'b0;
      m_we       <= 1'b0;
      m_addr     <= '0;
      m_wdata    <= '0;
      m_wstrb    <= '0;
    end else begin
      state_q    <= state_d;
      cur_port   <= cur_port_d;
      last_grant <= last_grant_d;
      wdog       <= wdog_d;
      if_ack     <= if_ack_d;
      dm_ack     <= dm_ack_d;
      rsp_rdata  <= rsp_rdata_d;
      rsp_err    <= rsp_err_d;
      m_req      <= m_req_d;
      m_we       <= m_we_d;
      m_addr     <= m_addr_d;
      m_wdata    <= m_wdata_d;
      m_wstrb    <= m_wstrb_d;
    end
  end

endmodule

// File: tb/tb_mem_bus_arbiter.sv
// Testbench: tb_mem_bus_arbiter
// Purpose: directed checks of mem_bus_arbiter. Instance A uses round-robin
//   ties and TIMEOUT=8; instance B shares every input but uses DM priority and
//   a disabled watchdog. Inputs are driven and outputs sampled on the falling
//   clock edge, so each table row describes one full clock cycle.
module tb_mem_bus_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, dm_req, dm_we, m_ack;
  logic [31:0] if_addr, dm_addr, dm_wdata, m_rdata;
  logic [3:0]  dm_wstrb;

  logic        a_if_ack, a_dm_ack, a_rsp_err, a_m_req, a_m_we;
  logic [31:0] a_rsp_rdata, a_m_addr, a_m_wdata;
  logic [3:0]  a_m_wstrb;
  logic        b_if_ack, b_dm_ack, b_rsp_err, b_m_req, b_m_we;
  logic [31:0] b_rsp_rdata, b_m_addr, b_m_wdata;
  logic [3:0]  b_m_wstrb;

  int n_compared   = 0;
  int n_mismatched = 0;

  always #5 clk = ~clk;

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_DATA(0), .TIMEOUT(8)) dut_a (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(a_if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_ack(a_dm_ack),
    .rsp_rdata(a_rsp_rdata), .rsp_err(a_rsp_err),
    .m_req(a_m_req), .m_we(a_m_we), .m_addr(a_m_addr), .m_wdata(a_m_wdata),
    .m_wstrb(a_m_wstrb), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  mem_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .PRIO_DATA(1), .TIMEOUT(0)) dut_b (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_ack(b_if_ack),
    .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr), .dm_wdata(dm_wdata),
    .dm_wstrb(dm_wstrb), .dm_ack(b_dm_ack),
    .rsp_rdata(b_rsp_rdata), .rsp_err(b_rsp_err),
    .m_req(b_m_req), .m_we(b_m_we), .m_addr(b_m_addr), .m_wdata(b_m_wdata),
    .m_wstrb(b_m_wstrb), .m_ack(m_ack), .m_rdata(m_rdata)
  );

  typedef struct {
    logic        if_req;
    logic [31:0] if_addr;
    logic        dm_req;
    logic        dm_we;
    logic [31:0] dm_addr;
    logic [31:0] dm_wdata;
    logic [3:0]  dm_wstrb;
    logic        m_ack;
    logic [31:0] m_rdata;
    logic        e_m_req;
    logic        e_m_we;
    logic [31:0] e_m_addr;
    logic [31:0] e_m_wdata;
    logic [3:0]  e_m_wstrb;
    logic        e_if_ack;
    logic        e_dm_ack;
    logic [31:0] e_rdata;
    logic        e_err;
  } vec_t;

  vec_t vecs[$];

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp_v);
    n_compared++;
    if (act !== exp_v) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp_v);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    if_req   = v.if_req;
    if_addr  = v.if_addr;
    dm_req   = v.dm_req;
    dm_we    = v.dm_we;
    dm_addr  = v.dm_addr;
    dm_wdata = v.dm_wdata;
    dm_wstrb = v.dm_wstrb;
    m_ack    = v.m_ack;
    m_rdata  = v.m_rdata;
  endtask

  // Bus command fields are only meaningful while m_req is expected high, and
  // response fields only while an ack is expected.
  task automatic checkRow(input int idx, input vec_t v);
    checkOutput($sformatf("row%0d m_req", idx), 32'(a_m_req), 32'(v.e_m_req));
    checkOutput($sformatf("row%0d if_ack", idx), 32'(a_if_ack), 32'(v.e_if_ack));
    checkOutput($sformatf("row%0d dm_ack", idx), 32'(a_dm_ack), 32'(v.e_dm_ack));
    if (v.e_m_req) begin
      checkOutput($sformatf("row%0d m_we", idx), 32'(a_m_we), 32'(v.e_m_we));
      checkOutput($sformatf("row%0d m_addr", idx), a_m_addr, v.e_m_addr);
      checkOutput($sformatf("row%0d m_wdata", idx), a_m_wdata, v.e_m_wdata);
      checkOutput($sformatf("row%0d m_wstrb", idx), 32'(a_m_wstrb), 32'(v.e_m_wstrb));
    end
    if (v.e_if_ack || v.e_dm_ack) begin
      checkOutput($sformatf("row%0d rsp_rdata", idx), a_rsp_rdata, v.e_rdata);
      checkOutput($sformatf("row%0d rsp_err", idx), 32'(a_rsp_err), 32'(v.e_err));
    end
  endtask

  initial begin
    int exp_a_dm[4];
    int exp_b_dm[4];

    rst = 1'b1;
    applyStimulus('{1'b0, 32'h0, 1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 32'h0,
                    1'b0, 1'b0, 32'h0, 32'h0, 4'h0, 1'b0, 1'b0, 32'h0, 1'b0});

    // Table: inputs (if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata, dm_wstrb, m_ack, m_rdata)
    //        expected (m_req, m_we, m_addr, m_wdata, m_wstrb, if_ack, dm_ack, rsp_rdata, rsp_err)
    // IF read, slave acks in the second m_req cycle
    vecs.push_back('{1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    vecs.push_back('{1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,  1, 0, 32'h100, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    vecs.push_back('{1, 32'h100, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'hDEADBEEF,  1, 0, 32'h100, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'hDEADBEEF, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    // spurious m_ack while idle
    vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 1, 32'h55555555,  0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    // DM write; the address input wobbles during BUSY but the bus must not
    vecs.push_back('{0, 32'h0, 1, 1, 32'h20000004, 32'h12345678, 4'h3, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 32'h0, 1, 1, 32'h20000004, 32'h12345678, 4'h3, 0, 32'h0,  1, 1, 32'h20000004, 32'h12345678, 4'h3, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 32'h0, 1, 1, 32'hFFFF0000, 32'h12345678, 4'h3, 0, 32'h0,  1, 1, 32'h20000004, 32'h12345678, 4'h3, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 32'h0, 1, 1, 32'h20000004, 32'h12345678, 4'h3, 1, 32'hAAAA0000,  1, 1, 32'h20000004, 32'h12345678, 4'h3, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'hAAAA0000, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    // DM read acked in the first m_req cycle
    vecs.push_back('{0, 32'h0, 1, 0, 32'h3000, 32'h0, 4'h0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 32'h0, 1, 0, 32'h3000, 32'h0, 4'h0, 1, 32'hCAFEF00D,  1, 0, 32'h3000, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 1, 32'hCAFEF00D, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    // IF grant must zero we/wdata/wstrb even with DM data pins busy
    vecs.push_back('{1, 32'h104, 0, 1, 32'h0, 32'hFFFFFFFF, 4'hF, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    vecs.push_back('{1, 32'h104, 0, 1, 32'h0, 32'hFFFFFFFF, 4'hF, 1, 32'h01020304,  1, 0, 32'h104, 32'h0, 4'h0, 0, 0, 32'h0, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 1, 0, 32'h01020304, 0});
    vecs.push_back('{0, 32'h0, 0, 0, 32'h0, 32'h0, 4'h0, 0, 32'h0,  0, 0, 32'h0, 32'h0, 4'h0, 0, 0, 32'h0, 0});

    // Reset state
    repeat (2) @(negedge clk);
    checkOutput("reset a_m_req", 32'(a_m_req), 32'h0);
    checkOutput("reset a_if_ack", 32'(a_if_ack), 32'h0);
    checkOutput("reset a_dm_ack", 32'(a_dm_ack), 32'h0);
    checkOutput("reset a_rsp_rdata", a_rsp_rdata, 32'h0);
    checkOutput("reset a_rsp_err", 32'(a_rsp_err), 32'h0);
    checkOutput("reset a_m_addr", a_m_addr, 32'h0);
    checkOutput("reset a_m_we", 32'(a_m_we), 32'h0);
    checkOutput("reset b_m_req", 32'(b_m_req), 32'h0);
    rst = 1'b0;

    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      applyStimulus(vecs[i]);
      checkRow(i, vecs[i]);
    end

    // Tie sequence from a fresh reset: A alternates starting with IF, B always DM
    @(negedge clk);
    rst = 1'b1;
    if_req = 1'b0; dm_req = 1'b0; m_ack = 1'b0; dm_we = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    if_req = 1'b1; if_addr = 32'h40;
    dm_req = 1'b1; dm_addr = 32'h80; dm_wdata = 32'h0; dm_wstrb = 4'h0;
    exp_a_dm = '{0, 1, 0, 1};
    exp_b_dm = '{1, 1, 1, 1};
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checkOutput($sformatf("tie%0d a_m_req", k), 32'(a_m_req), 32'h1);
      checkOutput($sformatf("tie%0d a_m_addr", k), a_m_addr, (exp_a_dm[k] != 0) ? 32'h80 : 32'h40);
      checkOutput($sformatf("tie%0d b_m_addr", k), b_m_addr, (exp_b_dm[k] != 0) ? 32'h80 : 32'h40);
      m_ack = 1'b1; m_rdata = 32'(k);
      @(negedge clk);
      m_ack = 1'b0;
      checkOutput($sformatf("tie%0d a_if_ack", k), 32'(a_if_ack), (exp_a_dm[k] != 0) ? 32'h0 : 32'h1);
      checkOutput($sformatf("tie%0d a_dm_ack", k), 32'(a_dm_ack), (exp_a_dm[k] != 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("tie%0d b_dm_ack", k), 32'(b_dm_ack), (exp_b_dm[k] != 0) ? 32'h1 : 32'h0);
      checkOutput($sformatf("tie%0d a_rsp_rdata", k), a_rsp_rdata, 32'(k));
      if (k == 3) begin
        if_req = 1'b0; dm_req = 1'b0;
      end
      @(negedge clk);
      checkOutput($sformatf("tie%0d idle a_m_req", k), 32'(a_m_req), 32'h0);
    end

    // Watchdog: slave never answers, A aborts after 8 BUSY cycles, B keeps waiting
    if_req = 1'b1; if_addr = 32'h500;
    for (int c = 1; c <= 8; c++) begin
      @(negedge clk);
      checkOutput($sformatf("tmo busy%0d a_m_req", c), 32'(a_m_req), 32'h1);
    end
    @(negedge clk);
    checkOutput("tmo a_m_req", 32'(a_m_req), 32'h0);
    checkOutput("tmo a_if_ack", 32'(a_if_ack), 32'h1);
    checkOutput("tmo a_rsp_err", 32'(a_rsp_err), 32'h1);
    checkOutput("tmo a_rsp_rdata", a_rsp_rdata, 32'h0);
    checkOutput("tmo b_m_req still held", 32'(b_m_req), 32'h1);
    if_req = 1'b0;
    @(negedge clk);
    checkOutput("tmo ack pulse end", 32'(a_if_ack), 32'h0);

    // Next request: m_ack lands in the would-be timeout cycle and wins
    if_req = 1'b1; if_addr = 32'h600;
    for (int c = 1; c <= 7; c++) begin
      @(negedge clk);
      checkOutput($sformatf("late busy%0d a_m_req", c), 32'(a_m_req), 32'h1);
    end
    @(negedge clk);
    checkOutput("late busy8 a_m_req", 32'(a_m_req), 32'h1);
    checkOutput("late a_m_addr", a_m_addr, 32'h600);
    m_ack = 1'b1; m_rdata = 32'h600D600D;
    @(negedge clk);
    m_ack = 1'b0; if_req = 1'b0;
    checkOutput("late a_if_ack", 32'(a_if_ack), 32'h1);
    checkOutput("late a_rsp_err", 32'(a_rsp_err), 32'h0);
    checkOutput("late a_rsp_rdata", a_rsp_rdata, 32'h600D600D);
    @(negedge clk);
    checkOutput("late ack pulse end", 32'(a_if_ack), 32'h0);

    // Reset mid-BUSY drops m_req immediately; the reissued request then completes
    if_req = 1'b1; if_addr = 32'h700;
    @(negedge clk);
    checkOutput("rstmid a_m_req before", 32'(a_m_req), 32'h1);
    #2 rst = 1'b1;
    #1;
    checkOutput("rstmid a_m_req async", 32'(a_m_req), 32'h0);
    checkOutput("rstmid b_m_req async", 32'(b_m_req), 32'h0);
    checkOutput("rstmid a_if_ack", 32'(a_if_ack), 32'h0);
    @(negedge clk);
    rst = 1'b0; if_addr = 32'h704;
    @(negedge clk);
    checkOutput("rstmid reissue a_m_req", 32'(a_m_req), 32'h1);
    checkOutput("rstmid reissue a_m_addr", a_m_addr, 32'h704);
    m_ack = 1'b1; m_rdata = 32'h0BADF00D;
    @(negedge clk);
    m_ack = 1'b0; if_req = 1'b0;
    checkOutput("rstmid reissue a_if_ack", 32'(a_if_ack), 32'h1);
    checkOutput("rstmid reissue a_rsp_rdata", a_rsp_rdata, 32'h0BADF00D);
    checkOutput("rstmid reissue a_rsp_err", 32'(a_rsp_err), 32'h0);
    @(negedge clk);
    checkOutput("rstmid ack pulse end", 32'(a_if_ack), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule
